// File: rtl/pattern_loader_pkg.sv
// Shared types and defaults for the pattern loader: load modes, FSM states and
// the grid cursor position type.
package pattern_loader_pkg;

  localparam int DEF_GRID_W = 64;
  localparam int DEF_GRID_H = 64;

  // Cursor position type; X_W of a default-sized loader matches this width.
  localparam int POS_W = $clog2(DEF_GRID_W);
  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    LOAD_OVERWRITE = 2'b00,
    LOAD_MERGE     = 2'b01,
    LOAD_CLEAR     = 2'b10,
    LOAD_RESERVED  = 2'b11
  } load_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } load_state_t;

  function automatic logic mode_is_valid(input logic [1:0] mode);
    return mode != LOAD_RESERVED;
  endfunction

endpackage

// File: rtl/pattern_loader_wrap.sv
// Modulo-MAX coordinate register: loads an origin, then steps by one with
// wrap-around, so a cursor walks a toroidal axis without any divider.
module wrap_counter #(
  parameter int MAX = 64,
  parameter int W   = $clog2(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] origin,
  input  logic         inc,
  output logic [W-1:0] coord
);

  localparam logic [W:0]   MAX_V = (W+1)'(MAX);
  localparam logic [W-1:0] MAX_T = W'(MAX);
  localparam logic [W-1:0] LAST  = W'(MAX - 1);
  localparam logic [W-1:0] ONE   = W'(1);

  logic [W-1:0] origin_norm;
  logic [W-1:0] coord_next;

  // An out-of-range origin (only possible when MAX is not a power of two)
  // is folded back by a single conditional subtract.
  always_comb begin
    origin_norm = ({1'b0, origin} >= MAX_V) ? origin - MAX_T : origin;
    coord_next  = (coord == LAST) ? '0 : coord + ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coord <= '0;
    end else if (load) begin
      coord <= origin_norm;
    end else if (inc) begin
      coord <= coord_next;
    end
  end

endmodule

// File: rtl/pattern_loader.sv
// Streams a packed, row-major cell pattern into the life grid write port at a
// chosen origin, with overwrite, merge and clear-rectangle modes.
module pattern_loader
  import pattern_loader_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H,
  parameter int X_W    = $clog2(GRID_W),
  parameter int Y_W    = $clog2(GRID_H)
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           start_in,
  input  logic           abort_in,
  input  logic [1:0]     mode_in,
  input  logic [X_W-1:0] origin_x_in,
  input  logic [Y_W-1:0] origin_y_in,
  input  logic [X_W:0]   pat_w_in,
  input  logic [Y_W:0]   pat_h_in,
  input  logic [7:0]     byte_in,
  input  logic           byte_valid_in,
  output logic           byte_ready_out,
  output logic [X_W-1:0] cell_x_out,
  output logic [Y_W-1:0] cell_y_out,
  output logic           alive_out,
  output logic           wr_en_out,
  input  logic           wr_ready_in,
  output logic           busy_out,
  output logic           done_out,
  output logic           err_out
);

  localparam logic [X_W:0] MAX_W = (X_W+1)'(GRID_W);
  localparam logic [Y_W:0] MAX_H = (Y_W+1)'(GRID_H);
  localparam logic [X_W:0] ONE_W = (X_W+1)'(1);
  localparam logic [Y_W:0] ONE_H = (Y_W+1)'(1);

  // Handshakes:
  //   byte port : a byte moves on a cycle where byte_valid_in && byte_ready_out.
  //   write port: a cell is written on a cycle where wr_en_out && wr_ready_in;
  //               while wr_en_out is high without wr_ready_in the address and
  //               alive_out hold. abort_in masks both ready and enable.
  load_state_t    state_q, state_d;
  load_mode_t     mode_q;
  logic [X_W-1:0] origin_x_q;
  logic [Y_W-1:0] origin_y_q;
  logic [X_W:0]   pat_w_q, col_q, col_d;
  logic [Y_W:0]   pat_h_q, row_q, row_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_q, bit_d;
  logic           err_q, err_d;

  logic           latch, start_ok, advance;
  logic           last_col, last_row;
  logic           wr_en_raw, ready_raw, alive_raw;
  logic           x_load, x_inc, y_load, y_inc;
  logic [X_W-1:0] x_origin;
  logic [Y_W-1:0] y_origin;

  always_comb begin
    start_ok = (pat_w_in != '0) && (pat_w_in <= MAX_W) &&
               (pat_h_in != '0) && (pat_h_in <= MAX_H) &&
               mode_is_valid(mode_in);
    last_col = (col_q == pat_w_q - ONE_W);
    last_row = (row_q == pat_h_q - ONE_H);
    // The cursors load straight from the ports on start, and from the
    // latched origin when a row wraps back to the left edge.
    x_origin = (state_q == ST_IDLE) ? origin_x_in : origin_x_q;
    y_origin = (state_q == ST_IDLE) ? origin_y_in : origin_y_q;
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    err_d     = 1'b0;
    latch     = 1'b0;
    advance   = 1'b0;
    wr_en_raw = 1'b0;
    ready_raw = 1'b0;
    alive_raw = 1'b0;
    x_load    = 1'b0;
    x_inc     = 1'b0;
    y_load    = 1'b0;
    y_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          latch  = 1'b1;
          x_load = 1'b1;
          y_load = 1'b1;
          col_d  = '0;
          row_d  = '0;
          if (!start_ok) begin
            err_d = 1'b1;
          end else if (load_mode_t'(mode_in) == LOAD_CLEAR) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end

      ST_FETCH: begin
        ready_raw = 1'b1;
        if (byte_valid_in && !abort_in) begin
          shift_d = byte_in;
          bit_d   = '0;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        case (mode_q)
          LOAD_MERGE: begin
            wr_en_raw = shift_q[0];
            alive_raw = 1'b1;
          end
          LOAD_CLEAR: begin
            wr_en_raw = 1'b1;
            alive_raw = 1'b0;
          end
          default: begin
            wr_en_raw = 1'b1;
            alive_raw = shift_q[0];
          end
        endcase
        // A merge dead cell has nothing to write and moves on at once.
        advance = !abort_in && (!wr_en_raw || wr_ready_in);
        if (advance) begin
          if (last_col && last_row) begin
            state_d = ST_DONE;
          end else if (last_col) begin
            col_d   = '0;
            row_d   = row_q + ONE_H;
            x_load  = 1'b1;
            y_inc   = 1'b1;
            // Rows always begin on a fresh byte; leftover padding is dropped.
            state_d = (mode_q == LOAD_CLEAR) ? ST_WRITE : ST_FETCH;
          end else begin
            col_d   = col_q + ONE_W;
            x_inc   = 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7 && mode_q != LOAD_CLEAR) begin
              state_d = ST_FETCH;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort_in && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      mode_q     <= LOAD_OVERWRITE;
      origin_x_q <= '0;
      origin_y_q <= '0;
      pat_w_q    <= '0;
      pat_h_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
      if (latch) begin
        mode_q     <= load_mode_t'(mode_in);
        origin_x_q <= origin_x_in;
        origin_y_q <= origin_y_in;
        pat_w_q    <= pat_w_in;
        pat_h_q    <= pat_h_in;
      end
    end
  end

  wrap_counter #(.MAX(GRID_W), .W(X_W)) u_col_wrap (
    .clk    (clk_in),
    .rst    (rst_in),
    .load   (x_load),
    .origin (x_origin),
    .inc    (x_inc),
    .coord  (cell_x_out)
  );

  wrap_counter #(.MAX(GRID_H), .W(Y_W)) u_row_wrap (
    .clk    (clk_in),
    .rst    (rst_in),
    .load   (y_load),
    .origin (y_origin),
    .inc    (y_inc),
    .coord  (cell_y_out)
  );

  // abort_in gates the port strobes combinationally so nothing moves that cycle.
  assign wr_en_out      = wr_en_raw && !abort_in;
  assign byte_ready_out = ready_raw && !abort_in;
  assign alive_out      = alive_raw;
  assign busy_out       = (state_q != ST_IDLE);
  assign done_out       = (state_q == ST_DONE) && !abort_in;
  assign err_out        = err_q;

endmodule

// File: tb/tb_pattern_loader.sv
// Bench for pattern_loader: random and directed loads checked against a
// cell-list reference model built from origin, size, mode and the byte stream.
module tb_pattern_loader;

  localparam int GRID_W = 64;
  localparam int GRID_H = 64;
  localparam int X_W    = 6;
  localparam int Y_W    = 6;
  localparam int EW     = X_W + Y_W + 1;

  logic           clk, rst_in;
  logic           start_in, abort_in;
  logic [1:0]     mode_in;
  logic [X_W-1:0] origin_x_in;
  logic [Y_W-1:0] origin_y_in;
  logic [X_W:0]   pat_w_in;
  logic [Y_W:0]   pat_h_in;
  logic [7:0]     byte_in;
  logic           byte_valid_in, byte_ready_out;
  logic [X_W-1:0] cell_x_out;
  logic [Y_W-1:0] cell_y_out;
  logic           alive_out, wr_en_out, wr_ready_in;
  logic           busy_out, done_out, err_out;

  int vectors     = 0;
  int miscompares = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  logic [7:0]    src_q[$];
  logic [7:0]    model_bytes[$];
  int byte_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, rdy_cnt = 0;

  pattern_loader #(.GRID_W(GRID_W), .GRID_H(GRID_H)) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .abort_in       (abort_in),
    .mode_in        (mode_in),
    .origin_x_in    (origin_x_in),
    .origin_y_in    (origin_y_in),
    .pat_w_in       (pat_w_in),
    .pat_h_in       (pat_h_in),
    .byte_in        (byte_in),
    .byte_valid_in  (byte_valid_in),
    .byte_ready_out (byte_ready_out),
    .cell_x_out     (cell_x_out),
    .cell_y_out     (cell_y_out),
    .alive_out      (alive_out),
    .wr_en_out      (wr_en_out),
    .wr_ready_in    (wr_ready_in),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .err_out        (err_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- monitor (sampled on the falling edge) ----------------
  always @(negedge clk) begin
    if (!rst_in) begin
      if (wr_en_out && wr_ready_in) obs_q.push_back({cell_x_out, cell_y_out, alive_out});
      if (byte_valid_in && byte_ready_out) byte_cnt++;
      if (done_out) done_cnt++;
      if (err_out) err_cnt++;
      if (busy_out) busy_cnt++;
      if (byte_ready_out) rdy_cnt++;
    end
  end

  // ---------------- reference model ----------------
  function automatic void build_model(input logic [1:0] mode, input int ox, input int oy,
                                      input int w, input int h);
    int bpr, x, y;
    logic b;
    exp_q.delete();
    bpr = (w + 7) / 8;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        x = (ox + c) % GRID_W;
        y = (oy + r) % GRID_H;
        if (mode == 2'b10) begin
          exp_q.push_back({X_W'(x), Y_W'(y), 1'b0});
        end else begin
          b = model_bytes[r * bpr + c / 8][c % 8];
          if (mode == 2'b00) exp_q.push_back({X_W'(x), Y_W'(y), b});
          else if (b) exp_q.push_back({X_W'(x), Y_W'(y), 1'b1});
        end
      end
    end
  endfunction

  // ---------------- driver ----------------
  task automatic do_load(input logic [1:0] mode, input int ox, input int oy, input int w,
                         input int h, input int rdy_pct, input int vld_pct, input int stall_x,
                         input int restart_at, output int busy_used);
    int bpr, nbytes, exp_bytes, base_obs, b_bytes, b_done, b_err, b_busy;
    int cyc, budget, stall_left, nobs;
    logic finished, held, take;
    logic [EW-1:0] held_val;
    bpr       = (w + 7) / 8;
    exp_bytes = (mode == 2'b10) ? 0 : h * bpr;
    nbytes    = (mode == 2'b10) ? 4 : exp_bytes;
    while (src_q.size() < nbytes) src_q.push_back(8'($urandom));
    model_bytes = src_q;
    build_model(mode, ox, oy, w, h);
    base_obs = obs_q.size();
    b_bytes  = byte_cnt;
    b_done   = done_cnt;
    b_err    = err_cnt;
    b_busy   = busy_cnt;

    @(posedge clk); #1;
    start_in    = 1'b1;
    mode_in     = mode;
    origin_x_in = X_W'(ox);
    origin_y_in = Y_W'(oy);
    pat_w_in    = (X_W+1)'(w);
    pat_h_in    = (Y_W+1)'(h);
    @(posedge clk); #1;
    start_in = 1'b0;

    finished   = 1'b0;
    held       = 1'b0;
    held_val   = '0;
    cyc        = 0;
    stall_left = 3;
    budget     = 12 * (w * h + exp_bytes) + 50;
    while (!finished && cyc < budget) begin
      if (cyc == restart_at) begin
        start_in = 1'b1;
        mode_in  = 2'b11;
        pat_w_in = '0;
      end else begin
        start_in = 1'b0;
      end
      byte_valid_in = (src_q.size() > 0) && ($urandom_range(99) < vld_pct);
      byte_in       = (src_q.size() > 0) ? src_q[0] : 8'h00;
      if (stall_x >= 0 && wr_en_out && int'(cell_x_out) == stall_x && stall_left > 0) begin
        wr_ready_in = 1'b0;
        stall_left--;
      end else begin
        wr_ready_in = ($urandom_range(99) < rdy_pct);
      end
      @(negedge clk);
      if (held) begin
        vectors++;
        if (!(wr_en_out && {cell_x_out, cell_y_out, alive_out} == held_val)) begin
          miscompares++;
          $display("FAIL hold: got en=%b cell=%h, expected en=1 cell=%h", wr_en_out,
                   {cell_x_out, cell_y_out, alive_out}, held_val);
        end
      end
      held     = wr_en_out && !wr_ready_in;
      held_val = {cell_x_out, cell_y_out, alive_out};
      take     = byte_valid_in && byte_ready_out;
      if (done_out) finished = 1'b1;
      @(posedge clk); #1;
      if (take) void'(src_q.pop_front());
      cyc++;
    end
    start_in      = 1'b0;
    byte_valid_in = 1'b0;
    wr_ready_in   = 1'b0;
    src_q.delete();

    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL done_timeout: no done_out within %0d cycles", budget);
      abort_in = 1'b1;
      @(posedge clk); #1;
      abort_in = 1'b0;
    end

    nobs = obs_q.size() - base_obs;
    vectors++;
    if (nobs != exp_q.size()) begin
      miscompares++;
      $display("FAIL write_count: got %0d, expected %0d", nobs, exp_q.size());
    end
    for (int i = 0; i < nobs && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[base_obs + i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL write[%0d]: got x=%0d y=%0d a=%b, expected x=%0d y=%0d a=%b", i,
                 obs_q[base_obs+i][EW-1 -: X_W], obs_q[base_obs+i][Y_W:1], obs_q[base_obs+i][0],
                 exp_q[i][EW-1 -: X_W], exp_q[i][Y_W:1], exp_q[i][0]);
      end
    end
    vectors++;
    if (byte_cnt - b_bytes != exp_bytes) begin
      miscompares++;
      $display("FAIL bytes_used: got %0d, expected %0d", byte_cnt - b_bytes, exp_bytes);
    end
    vectors++;
    if (done_cnt - b_done != 1) begin
      miscompares++;
      $display("FAIL done_pulses: got %0d, expected 1", done_cnt - b_done);
    end
    vectors++;
    if (err_cnt - b_err != 0) begin
      miscompares++;
      $display("FAIL err_pulses: got %0d, expected 0", err_cnt - b_err);
    end
    busy_used = busy_cnt - b_busy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy_out, done_out, err_out, wr_en_out, byte_ready_out, alive_out,
         cell_x_out, cell_y_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b en=%b rdy=%b x=%0d y=%0d, expected all 0",
               busy_out, done_out, err_out, wr_en_out, byte_ready_out, cell_x_out, cell_y_out);
    end
    @(posedge clk); #1;
    rst_in = 1'b0;
  endtask

  task automatic test_overwrite_wrap();
    int busy_used, n;
    logic [EW-1:0] hand[3];
    int hand_idx[3];
    hand[0] = {6'd62, 6'd63, 1'b1}; hand_idx[0] = 0;
    hand[1] = {6'd0,  6'd63, 1'b1}; hand_idx[1] = 2;
    hand[2] = {6'd63, 6'd0,  1'b1}; hand_idx[2] = 4;
    src_q.push_back(8'h05);
    src_q.push_back(8'h02);
    do_load(2'b00, 62, 63, 3, 2, 100, 100, -1, -1, busy_used);
    n = obs_q.size();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (n < 6 || obs_q[n - 6 + hand_idx[k]] !== hand[k]) begin
        miscompares++;
        $display("FAIL wrap_cell[%0d]: got %h, expected %h", hand_idx[k],
                 (n < 6) ? '0 : obs_q[n - 6 + hand_idx[k]], hand[k]);
      end
    end
    vectors++;
    if (busy_used != 9) begin
      miscompares++;
      $display("FAIL wrap_cycles: got %0d busy cycles, expected 9", busy_used);
    end
  endtask

  task automatic test_merge();
    int busy_used;
    src_q.push_back(8'h81);
    do_load(2'b01, 10, 10, 8, 1, 100, 100, -1, -1, busy_used);
    vectors++;
    if (busy_used != 10) begin
      miscompares++;
      $display("FAIL merge_cycles: got %0d busy cycles, expected 10", busy_used);
    end
  endtask

  task automatic test_backpressure();
    int busy_used;
    src_q.push_back(8'h0F);
    do_load(2'b00, 20, 7, 4, 1, 100, 100, 21, -1, busy_used);
    vectors++;
    if (busy_used != 9) begin
      miscompares++;
      $display("FAIL stall_cycles: got %0d busy cycles, expected 9", busy_used);
    end
  endtask

  task automatic test_clear();
    int busy_used, b_rdy;
    b_rdy = rdy_cnt;
    do_load(2'b10, 0, 0, 16, 16, 100, 100, -1, -1, busy_used);
    vectors++;
    if (busy_used != 257) begin
      miscompares++;
      $display("FAIL clear_cycles: got %0d busy cycles, expected 257", busy_used);
    end
    vectors++;
    if (rdy_cnt != b_rdy) begin
      miscompares++;
      $display("FAIL clear_ready: got %0d ready cycles, expected 0", rdy_cnt - b_rdy);
    end
  endtask

  task automatic test_errors();
    int ew[5] = '{0, 4, 65, 3, 4};
    int eh[5] = '{4, 4, 2, 0, 65};
    int em[5] = '{0, 3, 1, 0, 2};
    int b_err, base;
    b_err = err_cnt;
    base  = obs_q.size();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start_in    = 1'b1;
      mode_in     = 2'(em[k]);
      origin_x_in = 6'd3;
      origin_y_in = 6'd3;
      pat_w_in    = (X_W+1)'(ew[k]);
      pat_h_in    = (Y_W+1)'(eh[k]);
      @(posedge clk); #1;
      start_in = 1'b0;
      @(negedge clk);
      vectors++;
      if (err_out !== 1'b1 || busy_out !== 1'b0) begin
        miscompares++;
        $display("FAIL err_pulse[%0d]: got err=%b busy=%b, expected err=1 busy=0", k, err_out, busy_out);
      end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if (err_out !== 1'b0 || busy_out !== 1'b0) begin
        miscompares++;
        $display("FAIL err_width[%0d]: got err=%b busy=%b, expected err=0 busy=0", k, err_out, busy_out);
      end
    end
    vectors++;
    if (err_cnt - b_err != 5 || obs_q.size() != base) begin
      miscompares++;
      $display("FAIL err_effects: got %0d errs %0d writes, expected 5 errs 0 writes",
               err_cnt - b_err, obs_q.size() - base);
    end
  endtask

  task automatic test_start_while_busy();
    int busy_used;
    do_load(2'b10, 5, 5, 4, 2, 100, 100, -1, 2, busy_used);
  endtask

  task automatic test_abort();
    int base, b_done, b_bytes, cyc;
    logic aborted;
    base    = obs_q.size();
    b_done  = done_cnt;
    b_bytes = byte_cnt;
    aborted = 1'b0;
    @(posedge clk); #1;
    start_in    = 1'b1;
    mode_in     = 2'b00;
    origin_x_in = 6'd30;
    origin_y_in = 6'd40;
    pat_w_in    = 7'd8;
    pat_h_in    = 7'd8;
    @(posedge clk); #1;
    start_in = 1'b0;
    cyc = 0;
    while (!aborted && cyc < 100) begin
      byte_valid_in = 1'b1;
      byte_in       = 8'($urandom);
      wr_ready_in   = 1'b1;
      if (obs_q.size() - base == 4 && wr_en_out) begin
        abort_in = 1'b1;
        aborted  = 1'b1;
        @(negedge clk);
        vectors++;
        if (wr_en_out !== 1'b0 || byte_ready_out !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_gate: got en=%b rdy=%b, expected 0 0", wr_en_out, byte_ready_out);
        end
        @(posedge clk); #1;
        abort_in = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy_out !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_idle: got busy=%b, expected 0", busy_out);
        end
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    byte_valid_in = 1'b0;
    wr_ready_in   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (!aborted || obs_q.size() - base != 4 || done_cnt != b_done || byte_cnt - b_bytes != 1) begin
      miscompares++;
      $display("FAIL abort_result: got aborted=%b writes=%0d done=%0d bytes=%0d, expected 1 4 0 1",
               aborted, obs_q.size() - base, done_cnt - b_done, byte_cnt - b_bytes);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    start_in      = 1'b1;
    mode_in       = 2'b00;
    origin_x_in   = 6'd9;
    origin_y_in   = 6'd9;
    pat_w_in      = 7'd4;
    pat_h_in      = 7'd1;
    byte_valid_in = 1'b0;
    wr_ready_in   = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    @(negedge clk);
    vectors++;
    if (byte_ready_out !== 1'b1 || busy_out !== 1'b1 || cell_x_out !== 6'd9) begin
      miscompares++;
      $display("FAIL fetch_state: got rdy=%b busy=%b x=%0d, expected 1 1 9",
               byte_ready_out, busy_out, cell_x_out);
    end
    #2;
    rst_in = 1'b1;
    #1;
    vectors++;
    if ({busy_out, done_out, err_out, wr_en_out, byte_ready_out, alive_out,
         cell_x_out, cell_y_out} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got busy=%b rdy=%b en=%b x=%0d y=%0d, expected all 0",
               busy_out, byte_ready_out, wr_en_out, cell_x_out, cell_y_out);
    end
    wr_ready_in = 1'b0;
    @(posedge clk); #1;
    rst_in = 1'b0;
  endtask

  task automatic test_random();
    int busy_used;
    do_load(2'b00, 17, 5, 64, 2, 70, 70, -1, -1, busy_used);
    do_load(2'b01, 60, 62, 9, 3, 50, 50, -1, -1, busy_used);
    do_load(2'b00, 63, 0, 1, 64, 80, 80, -1, -1, busy_used);
    for (int i = 0; i < 8; i++) begin
      do_load(2'($urandom_range(2)), $urandom_range(63), $urandom_range(63),
              $urandom_range(1, 20), $urandom_range(1, 6), 60, 70, -1, -1, busy_used);
    end
  endtask

  initial begin
    rst_in        = 1'b1;
    start_in      = 1'b0;
    abort_in      = 1'b0;
    mode_in       = '0;
    origin_x_in   = '0;
    origin_y_in   = '0;
    pat_w_in      = '0;
    pat_h_in      = '0;
    byte_in       = '0;
    byte_valid_in = 1'b0;
    wr_ready_in   = 1'b0;

    test_reset();
    test_overwrite_wrap();
    test_merge();
    test_backpressure();
    test_clear();
    test_errors();
    test_start_while_busy();
    test_abort();
    test_async_reset();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pattern_loader.md
Name: pattern_loader

Overview:
- Streams a packed cell pattern (e.g. from the SD card reader) into the life grid write port at a chosen origin.
- Successor to the fixed-board integration, where the grid write port (alive/wr_en) is tied off.
- Sits between the byte source and life_logic's write port, and shares clk_in/rst_in with the rest of the clk_25mhz domain.
- Supports three modes: overwrite, merge (alive-only writes) and clear-rectangle. Supports toroidal wrap, abort, and write-port back-pressure.

Parameters:
GRID_W, 64, grid width in cells (≥8)
GRID_H, 64, grid height in cells (≥8)
X_W, $clog2(GRID_W), x coordinate width
Y_W, $clog2(GRID_H), y coordinate width

Ports:
clk_in  in  1  system clock; one clock domain
rst_in  in  1  reset; asynchronous, active-high
start_in  in  1  one-cycle load request; sampled only in IDLE
abort_in  in  1  cancel the current load
mode_in  in  2  00 overwrite, 01 merge, 10 clear, 11 reserved (error)
origin_x_in  in  X_W  destination column of pattern (0,0)
origin_y_in  in  Y_W  destination row of pattern (0,0)
pat_w_in  in  X_W+1  pattern width in cells, 1..GRID_W
pat_h_in  in  Y_W+1  pattern height in cells, 1..GRID_H
byte_in  in  8  pattern data byte
byte_valid_in  in  1  byte_in valid
byte_ready_out  out  1  loader accepts byte this cycle
cell_x_out  out  X_W  write column
cell_y_out  out  Y_W  write row
alive_out  out  1  value to write
wr_en_out  out  1  write request
wr_ready_in  in  1  grid accepts the write this cycle
busy_out  out  1  load in progress
done_out  out  1  one-cycle pulse on successful completion
err_out  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset: state IDLE. All outputs 0, counters 0, latched parameters 0.
- Data format:
  - Rows are row-major, top row first.
  - Each row starts on a fresh byte: ceil(pat_w/8) bytes per row, LSB = leftmost cell.
  - Padding bits in the last byte of a row are discarded.
- Start handling (IDLE, start_in=1):
  - Latch origin, size and mode.
  - If pat_w=0, pat_w>GRID_W, pat_h=0, pat_h>GRID_H or mode=11: err_out pulses next cycle, state stays IDLE, no writes.
  - Otherwise go to FETCH (overwrite/merge) or WRITE (clear). busy_out goes high the next cycle.
- start_in outside IDLE is ignored; no error.
- FETCH:
  - byte_ready_out=1.
  - On byte_valid_in & byte_ready_out: latch the byte into the shift register, bit index=0, go to WRITE.
  - byte_ready_out is 0 in every other state.
- WRITE, one cell per slot:
  - Address: cell_x=(origin_x+col) mod GRID_W, cell_y=(origin_y+row) mod GRID_H. Computed by add and conditional subtract; no divider.
  - Overwrite: wr_en_out=1, alive_out=current bit.
  - Merge: wr_en_out=current bit, alive_out=1. Dead cells take one cycle with no write.
  - Clear: wr_en_out=1, alive_out=0, no bytes consumed.
  - Valid/ready rule: wr_en_out, cell_x/y and alive_out hold stable until wr_ready_in=1. The slot advances only on handshake, or immediately for a merge dead cell.
- Advance after each slot:
  - col+1.
  - If col hits pat_w-1: col=0, row+1, and go to FETCH (non-clear) even if bits remain in the byte.
  - Else if bit index=7 (non-clear): go to FETCH.
- Completion:
  - The last cell (row=pat_h-1, col=pat_w-1) advances to DONE.
  - DONE lasts one cycle: done_out=1, busy_out=0 from the next cycle, then IDLE.
- abort_in (any non-IDLE state):
  - Next state IDLE; wr_en_out and byte_ready_out drop the same cycle (combinational gating).
  - No done_out. A partially written grid is left as is.
  - abort_in has priority over a simultaneous handshake; that write is not counted.
- Asynchronous reset mid-load: immediate IDLE, outputs 0.
- Throughput:
  - Overwrite with wr_ready_in=1: pat_w·pat_h write cycles + one FETCH cycle per byte.
  - Clear: pat_w·pat_h cycles + 1 (DONE).

Decomposition:
- Shared package (common.svh): load_mode_t enum (LOAD_OVERWRITE, LOAD_MERGE, LOAD_CLEAR), GRID_W/GRID_H defaults, and pos_t alignment so X_W matches the cursor position type.
- Sub-module wrap_counter (parametrised MAX, origin input, inc input, returns wrapped coordinate).
  - Instantiated twice: column/x and row/y.
  - Keeps the modular arithmetic testable alone.

Test Plan:
- Overwrite wrap: GRID 64×64, origin (62,63), 3×2, bytes 0x05,0x02, wr_ready=1.
  - Writes in order: (62,63)=1, (63,63)=0, (0,63)=1, (62,0)=0, (63,0)=1, (0,0)=0.
  - Exactly 6 writes, 2 bytes consumed, done_out pulses once.
- Merge: origin (10,10), 8×1, byte 0x81.
  - Only (10,10) and (17,10) are written, alive=1.
  - Completes in 1 FETCH + 8 WRITE + 1 DONE cycles.
- Back-pressure: overwrite 4×1, byte 0x0F, wr_ready_in low for 3 cycles on the second cell.
  - Address (origin_x+1) and wr_en_out stay stable; no duplicate or skipped writes.
- Clear: origin (0,0), 16×16, byte_valid_in held 1.
  - 256 writes with alive=0, byte_ready_out never asserted, done_out at cycle 257.
- Errors: start with pat_w=0 → err_out pulse, no writes. Start with mode=11 → err_out. Start while busy → ignored, no error.
- Abort/reset: abort_in during the 5th write of 8×8 overwrite → wr_en_out low that cycle, IDLE next, no done_out. Async rst_in mid-FETCH → all outputs 0 without a clock edge.
